mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port Avalon-MM arbiter: port 0 (instruction fetch) and port 1 (data)
// share one downstream memory master. Each transfer costs one arbitration
// (IDLE) cycle followed by the bus cycle(s) of the granted port.
module mem_bus_arbiter #(
  parameter int FIXED_PRIORITY = 0   // 0: round-robin on ties, 1: port 1 wins ties
) (
  input  logic        clk,
  input  logic        reset,          // asynchronous, active low

  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,

  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,

  output logic [31:0] m_readdata,

  output logic [31:0] address,
  output logic        write,
  output logic        read,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,

  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // port index of the most recent owner
  logic [1:0]  grant_q, grant_d;

  logic req0, req1;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Next-state: arbitrate only in IDLE; release on completion or on a dropped request
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          // Round-robin hands a tie to the port that did not own the bus last
          if ((FIXED_PRIORITY != 0) || (last_grant_q == 1'b0)) state_d = BUSY1;
          else                                                state_d = BUSY0;
        end else if (req0) begin
          state_d = BUSY0;
        end else if (req1) begin
          state_d = BUSY1;
        end
      end
      BUSY0:   if (!req0 || !waitrequest) state_d = IDLE;
      BUSY1:   if (!req1 || !waitrequest) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q == IDLE && state_d == BUSY0) last_grant_d = 1'b0;
    if (state_q == IDLE && state_d == BUSY1) last_grant_d = 1'b1;
    grant_d = {state_d == BUSY1, state_d == BUSY0};
  end

  // State, arbitration history and registered one-hot grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // port 0 wins the first tie after reset
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
    end
  end

  assign grant      = grant_q;
  assign m_readdata = readdata;

  // Downstream mux: owner's request passes through with no added latency;
  // a simultaneous read+write is issued as a write only
  always_comb begin
    address        = 32'h0;
    read           = 1'b0;
    write          = 1'b0;
    writedata      = 32'h0;
    byteenable     = 4'h0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      BUSY0: begin
        address        = m0_address;
        write          = m0_write;
        read           = m0_read & ~m0_write;
        writedata      = m0_writedata;
        byteenable     = m0_byteenable;
        m0_waitrequest = waitrequest;
      end
      BUSY1: begin
        address        = m1_address;
        write          = m1_write;
        read           = m1_read & ~m1_write;
        writedata      = m1_writedata;
        byteenable     = m1_byteenable;
        m1_waitrequest = waitrequest;
      end
      default: ;
    endcase
  end

endmodule
